bridge_router: RTL
==================

// Module: bridge_router
// PURPOSE
//  Parametrised, pipelined successor to the bridge address fan-out. Decodes host bridge
//  accesses against NUM_LEAVES address ranges, forwards registered write/read strobes to
//  one leaf, and returns the selected leaf's read data after a fixed, pipelined latency.
//  Back-to-back reads are supported. Unmapped accesses are flagged. Sits between apf bridge and core leaves.
// PARAMETERS
//  NUM_LEAVES   6          number of leaf ports, 1..16
//  ADDR_W       32         address width
//  DATA_W       32         data width, multiple of 8
//  RD_LATENCY   1          leaf cycles from leaf_rd to valid leaf_rd_data, 0..4
//  ADDR_RANGES  -          pocket::bridge_addr_range_t[NUM_LEAVES], inclusive from/to
//  UNMAPPED_DATA 0         read data returned for unmapped reads
//  LEAF_SWAP    '0         per-leaf byte-swap mask (used only with BRIDGE_ROUTER_BYTESWAP_EN)
// PORTS
//  clk_74a         in   1                 bridge clock
//  reset_n         in   1                 async active-low reset
//  bridge_addr     in   ADDR_W            host address
//  bridge_wr       in   1                 write strobe, 1 cycle
//  bridge_wr_data  in   DATA_W            write data
//  bridge_rd       in   1                 read strobe, 1 cycle
//  bridge_rd_data  out  DATA_W            read data, held until next read completes
//  leaf_addr       out  ADDR_W            registered address, broadcast to all leaves
//  leaf_wr_data    out  DATA_W            registered write data, broadcast
//  leaf_wr         out  NUM_LEAVES        one-hot write strobe
//  leaf_rd         out  NUM_LEAVES        one-hot read strobe
//  leaf_rd_data    in   NUM_LEAVES*DATA_W leaf i read data at [i*DATA_W +: DATA_W]
//  unmapped        out  1                 1-cycle pulse: access hit no range
//  unmapped_sticky out  1                 set by unmapped, cleared by unmapped_clr
//  unmapped_clr    in   1                 clears sticky; set wins if same cycle
// BEHAVIOUR
//  - Reset: all outputs 0; bridge_rd_data = 0; read pipeline flushed. Reset mid-read
//    discards in-flight reads; no late rd_data update after reset release.
//  - Decode: combinational; lowest index wins on overlapping ranges; hit = from<=addr<=to.
//  - Stage 1 (cycle T+1 after strobe at T): leaf_addr, leaf_wr_data, one-hot leaf_wr/leaf_rd
//    registered. Unmapped: no leaf strobe, unmapped pulses at T+1.
//  - rd and wr both high same cycle: both forwarded to the same leaf.
//  - Read pipeline: shift register of {valid, mapped, index}, depth RD_LATENCY+1. Leaf data
//    sampled RD_LATENCY cycles after leaf_rd; bridge_rd_data updated at T+2+RD_LATENCY.
//    Unmapped read updates bridge_rd_data to UNMAPPED_DATA at the same latency.
//  - One read may issue every cycle; each returns in order, independent of leaf index.
//  - Writes complete in stage 1; no write response.
//  - leaf_addr/leaf_wr_data hold last value between accesses.
// CONFIGURATION
//  BRIDGE_ROUTER_BYTESWAP_EN defined: for leaf i with LEAF_SWAP[i]=1, leaf_wr_data and the
//    returned read data are byte-reversed (wr swap in stage 1, rd swap at capture).
//  Undefined: LEAF_SWAP ignored, data passes unchanged; no swap logic synthesised.
// STRUCTURE
//  - pocket package: bridge_addr_range_t (existing), new MAX_LEAVES=16, byteswap function.
//  - Sub-module bridge_range_decode: combinational addr -> {hit, index}, priority encode.
//  - bridge_router: stage-1 registers, read pipeline, return mux, unmapped flags.
// TESTING
//  1 Write 0xDEADBEEF to 0xF8000010 (leaf0) -> leaf_wr=6'b000001 at T+1, leaf_addr=0xF8000010.
//  2 Read 0x00000040 (leaf3 returns 0x12345678), RD_LATENCY=1 -> bridge_rd_data=0x12345678 at T+3.
//  3 Reads on 3 consecutive cycles to leaves 0,3,5 -> three in-order returns at T+3,T+4,T+5.
//  4 Read 0x20000000 (unmapped) -> no leaf_rd, unmapped pulse T+1, sticky=1, rd_data=UNMAPPED_DATA;
//    unmapped_clr -> sticky=0; clr with new miss same cycle -> sticky stays 1.
//  5 Overlapping ranges leaf1/leaf2 at same addr -> only leaf_rd[1] asserted.
//  6 BRIDGE_ROUTER_BYTESWAP_EN, LEAF_SWAP[4]=1: write 0x11223344 to 0x00100000 -> leaf_wr_data
//    0x44332211; leaf read 0xAABBCCDD -> 0xDDCCBBAA. reset_n low at T+1 of a read -> no update.

Source files
------------

// File: rtl/pocket_pkg.sv
// Shared bridge types for the core: address-range descriptor, read-pipeline slot
// and a byte-reversal helper used by the leaf router.
package pocket;

   localparam int MAX_LEAVES = 16;
   localparam int IDX_W      = $clog2(MAX_LEAVES);
   localparam int MAX_DATA_W = 256;

   typedef struct packed {
      logic [31:0] from;
      logic [31:0] to;
   } bridge_addr_range_t;

   typedef struct packed {
      logic             valid;
      logic             mapped;
      logic [IDX_W-1:0] index;
   } rd_slot_t;

   // Reverses the lowest nbytes bytes of d; callers zero-extend in and truncate out.
   function automatic logic [MAX_DATA_W-1:0] byteswap(input logic [MAX_DATA_W-1:0] d,
                                                      input int nbytes);
      logic [MAX_DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_DATA_W / 8; i++) begin
         if (i < nbytes) r[i*8 +: 8] = d[(nbytes - 1 - i)*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/bridge_router_decode.sv
// Combinational address decoder: maps a host address to {hit, leaf index},
// lowest leaf index winning where ranges overlap.
module bridge_range_decode
   import pocket::*;
#(
   parameter int                 NUM_LEAVES  = 6,
   parameter int                 ADDR_W      = 32,
   parameter bridge_addr_range_t ADDR_RANGES [NUM_LEAVES] = '{default: '0}
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [IDX_W-1:0]  index
);

   logic [31:0] addr_ext;
   assign addr_ext = 32'(addr);

   // Scan downwards so the last assignment comes from the lowest matching leaf.
   always_comb begin
      hit   = 1'b0;
      index = '0;
      for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
         if (addr_ext >= ADDR_RANGES[i].from && addr_ext <= ADDR_RANGES[i].to) begin
            hit   = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/bridge_router.sv
// Bridge fan-out to NUM_LEAVES leaves with a pipelined, in-order read return path.
// Optional per-leaf byte swapping is compiled in with BRIDGE_ROUTER_BYTESWAP_EN.
module bridge_router
   import pocket::*;
#(
   parameter int                 NUM_LEAVES    = 6,
   parameter int                 ADDR_W        = 32,
   parameter int                 DATA_W        = 32,
   parameter int                 RD_LATENCY    = 1,
   parameter bridge_addr_range_t ADDR_RANGES [NUM_LEAVES] = '{default: '0},
   parameter logic [DATA_W-1:0]  UNMAPPED_DATA = '0,
   parameter logic [NUM_LEAVES-1:0] LEAF_SWAP  = '0
) (
   input  logic                         clk_74a,
   input  logic                         reset_n,
   input  logic [ADDR_W-1:0]            bridge_addr,
   input  logic                         bridge_wr,
   input  logic [DATA_W-1:0]            bridge_wr_data,
   input  logic                         bridge_rd,
   output logic [DATA_W-1:0]            bridge_rd_data,
   output logic [ADDR_W-1:0]            leaf_addr,
   output logic [DATA_W-1:0]            leaf_wr_data,
   output logic [NUM_LEAVES-1:0]        leaf_wr,
   output logic [NUM_LEAVES-1:0]        leaf_rd,
   input  logic [NUM_LEAVES*DATA_W-1:0] leaf_rd_data,
   output logic                         unmapped,
   output logic                         unmapped_sticky,
   input  logic                         unmapped_clr
);

   // Host strobes are single-cycle qualifiers with no back-pressure: every strobe is
   // accepted on the edge it is sampled, and each read returns exactly once, in order.

   logic                  dec_hit;
   logic [IDX_W-1:0]      dec_index;
   logic                  access;
   logic [NUM_LEAVES-1:0] dec_onehot;
   logic [DATA_W-1:0]     wr_data_fwd;
   logic [DATA_W-1:0]     ret_word;
   logic [DATA_W-1:0]     ret_data;
   rd_slot_t              pipe [RD_LATENCY+1];
   rd_slot_t              ret_slot;

   bridge_range_decode #(
      .NUM_LEAVES  (NUM_LEAVES),
      .ADDR_W      (ADDR_W),
      .ADDR_RANGES (ADDR_RANGES)
   ) u_decode (
      .addr  (bridge_addr),
      .hit   (dec_hit),
      .index (dec_index)
   );

   assign access     = bridge_rd | bridge_wr;
   assign dec_onehot = dec_hit ? (NUM_LEAVES'(1) << dec_index) : '0;
   assign ret_slot   = pipe[RD_LATENCY];

   always_comb begin
      ret_word = '0;
      for (int i = 0; i < NUM_LEAVES; i++) begin
         if (IDX_W'(i) == ret_slot.index) ret_word = leaf_rd_data[i*DATA_W +: DATA_W];
      end
   end

`ifdef BRIDGE_ROUTER_BYTESWAP_EN
   logic dec_swap;
   logic ret_swap;

   always_comb begin
      dec_swap = 1'b0;
      ret_swap = 1'b0;
      for (int i = 0; i < NUM_LEAVES; i++) begin
         if (IDX_W'(i) == dec_index)      dec_swap = LEAF_SWAP[i];
         if (IDX_W'(i) == ret_slot.index) ret_swap = LEAF_SWAP[i];
      end
   end

   assign wr_data_fwd = (dec_hit && dec_swap)
                        ? DATA_W'(byteswap(MAX_DATA_W'(bridge_wr_data), DATA_W / 8))
                        : bridge_wr_data;
   assign ret_data    = ret_swap
                        ? DATA_W'(byteswap(MAX_DATA_W'(ret_word), DATA_W / 8))
                        : ret_word;
`else
   logic unused_swap;
   assign unused_swap = ^LEAF_SWAP;
   assign wr_data_fwd = bridge_wr_data;
   assign ret_data    = ret_word;
`endif

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         leaf_addr       <= '0;
         leaf_wr_data    <= '0;
         leaf_wr         <= '0;
         leaf_rd         <= '0;
         unmapped        <= 1'b0;
         unmapped_sticky <= 1'b0;
      end else begin
         leaf_wr  <= bridge_wr ? dec_onehot : '0;
         leaf_rd  <= bridge_rd ? dec_onehot : '0;
         unmapped <= access && !dec_hit;
         if (access)    leaf_addr    <= bridge_addr;
         if (bridge_wr) leaf_wr_data <= wr_data_fwd;
         // A new miss beats a simultaneous clear so no event is ever lost.
         if (access && !dec_hit) unmapped_sticky <= 1'b1;
         else if (unmapped_clr)  unmapped_sticky <= 1'b0;
      end
   end

   // Slot k describes the read whose leaf_rd was asserted k cycles ago; the last slot
   // lines up with the leaf's data becoming valid.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i <= RD_LATENCY; i++) pipe[i] <= '0;
         bridge_rd_data <= '0;
      end else begin
         pipe[0] <= '{valid: bridge_rd, mapped: dec_hit, index: dec_index};
         for (int i = 1; i <= RD_LATENCY; i++) pipe[i] <= pipe[i-1];
         if (ret_slot.valid) bridge_rd_data <= ret_slot.mapped ? ret_data : UNMAPPED_DATA;
      end
   end

endmodule
